aux_keypad_scanner: RTL and testbench
=====================================

# aux_keypad_scanner

Scanned 4x4 matrix-keypad reader for the FPGA board top level. It is the input-side counterpart of the multiplexed seven-segment display driver: it drives one keypad column at a time, samples the rows, debounces full-matrix snapshots, and emits single-key press events. Events go to the core and debug logic through a one-entry valid/ready buffer, for example as a replacement for the resume button and debug switch inputs.

## Interface
Parameters:
- ScanCntMax, 25000: clock cycles each column is driven; must be ≥ 4.
- DebounceCnt, 4: consecutive identical snapshots required before a matrix state is accepted; must be ≥ 1.

Ports:
- clk  in  1  board clock; the only clock in the block.
- rst  in  1  synchronous, active-high reset.
- col_n  out  4  column drive, active-low; at most one bit is low.
- row_n  in  4  raw row inputs, active-low, externally pulled up, asynchronous.
- key_ready  in  1  consumer accepts the event on any edge where key_valid && key_ready.
- key_valid  out  1  press event pending.
- key_code  out  4  key index = col*4 + row.
- key_held  out  1  at least one key is down in the accepted (debounced) map.
- overflow  out  1  sticky flag: an event was dropped; cleared only by rst.

## Operation
- row_n passes through a 2-flop synchronizer before any use.
- FSM states:
  - SCAN: col register c (0..3) and dwell counter d (0..ScanCntMax-1). col_n = ~(4'b1 << c).
    - When d == ScanCntMax-1, write the inverted synchronized rows into snapshot bits [c*4+3:c*4].
    - If c == 3, go to EVAL. Otherwise c++ and d = 0.
  - EVAL: lasts exactly one cycle with col_n = 4'b1111. Next state is SCAN with c = 0, d = 0.
- Debounce, performed in EVAL:
  - If snapshot == prev_snap, match_cnt saturates upward at DebounceCnt-1. Otherwise prev_snap <= snapshot and match_cnt <= 0.
  - The snapshot is accepted once its match count reaches DebounceCnt-1, i.e. after DebounceCnt identical scans. On acceptance, stable_map <= snapshot.
- Event generation, also in EVAL on acceptance:
  - new = snapshot & ~stable_map.
  - An event is raised only when popcount(snapshot) == 1 and new != 0. key_code = index of that bit.
  - Any other case raises no event: releases, multi-key combinations, or a second key added to a held key.
- Output buffer:
  - An event loads key_code and sets key_valid.
  - If key_valid is already set and key_ready is low on that edge, the event is dropped, key_code stays unchanged, and overflow is set to 1.
  - If key_ready is high on the same edge, the new event is loaded and key_valid stays high.
  - key_valid && key_ready with no event clears key_valid.
- key_held = |stable_map.
- Widths:
  - d uses a clog2(ScanCntMax) counter.
  - match_cnt is max(1, clog2(DebounceCnt)) bits.
  - Snapshot and maps are 16 bits, with bit index = col*4 + row.

## Timing
- Reset values:
  - state = SCAN, c = 0, d = 0, col_n = 4'b1110.
  - snapshot, prev_snap and stable_map = 0; match_cnt = 0.
  - key_valid = 0, key_code = 0, key_held = 0, overflow = 0; synchronizer flops = 1.
- rst asserted mid-scan or mid-handshake returns every register to its reset value on that edge, and any pending event is lost.
- Scan period P = 4*ScanCntMax + 1 cycles.
- Row sampling happens ScanCntMax-1 cycles after a column is driven, which leaves at least 3 cycles for settling and synchronization.
- key_valid rises on the clock edge that ends EVAL. key_valid and key_code are registered with no combinational path from key_ready.
- Worst-case press-to-key_valid latency for a clean press is (DebounceCnt+1)*P + 3 cycles.
- key_code holds steady while key_valid is high and key_ready is low.

## Test plan
Use ScanCntMax=4 and DebounceCnt=2, giving P = 17.
- Reset: hold rst for 3 cycles → col_n=1110, key_valid=0, overflow=0; col_n then steps 1101 → 1011 → 0111 every 4 cycles, followed by one cycle of 1111.
- Single press: row 2 low whenever col 1 is driven, key_ready=0 → key_valid=1, key_code=6, key_held=1 within 54 cycles; key_valid then stays 1.
- Handshake: with key_valid=1 from the single-press case, pulse key_ready for 1 cycle → key_valid=0 the next cycle; keep holding the key → no new event. Release → key_held=0 within 3P+3, no event.
- Bounce: toggle row 0/col 0 on alternate scans for 6 scans, then hold → no event during the toggling; exactly one event with key_code=0 after 2 stable scans.
- Multi-key and overflow:
  - Press keys 3 and 12 together → no event.
  - Press key 5 and hold key_ready=0 → event loads key_code=5. Release, then press key 9 → key_code stays 5 and overflow=1.
  - Apply rst → overflow=0.
- Reset mid-event: assert rst while key_valid=1 → key_valid=0, key_held=0; with the key still held, the event re-fires after re-debounce.

Source files
------------

// File: rtl/aux_keypad_scanner.sv
// rtl/aux_keypad_scanner.sv - scanned 4x4 keypad reader with debounce and single-entry event buffer

module aux_keypad_scanner #(
  parameter int ScanCntMax  = 25000,
  parameter int DebounceCnt = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] col_n,
  input  logic [3:0] row_n,
  input  logic       key_ready,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held,
  output logic       overflow
);

  localparam int DW = $clog2(ScanCntMax);
  localparam int MW = (DebounceCnt > 1) ? $clog2(DebounceCnt) : 1;
  localparam logic [DW-1:0] DwellLast = DW'(ScanCntMax - 1);
  localparam logic [MW-1:0] MatchLast = MW'(DebounceCnt - 1);

  typedef enum logic {
    ST_SCAN,
    ST_EVAL
  } state_e;

  // Row synchronizer; idles high so a reset looks like "no key pressed".
  logic [3:0] row_meta_q, row_sync_q;

  state_e          state_q, state_d;
  logic [1:0]      col_q, col_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [15:0]     snap_q, snap_d;
  logic [15:0]     prev_q, prev_d;
  logic [15:0]     stable_q, stable_d;
  logic [MW-1:0]   match_q, match_d;
  logic            valid_q, valid_d;
  logic [3:0]      code_q, code_d;
  logic            ovf_q, ovf_d;

  logic [4:0]      ones;
  logic [3:0]      idx;
  logic            single_key;
  logic            event_fire;

  // Two-flop synchronizer for the asynchronous row inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
    end else begin
      row_meta_q <= row_n;
      row_sync_q <= row_meta_q;
    end
  end

  // Count pressed keys in the snapshot and locate the highest one; only
  // meaningful as an index when exactly one bit is set.
  always_comb begin
    ones = '0;
    idx  = '0;
    for (int i = 0; i < 16; i++) begin
      if (snap_q[i]) begin
        ones = ones + 5'd1;
        idx  = 4'(i);
      end
    end
  end

  assign single_key = (ones == 5'd1);

  // Scan sequencing, snapshot capture, debounce and event detection.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    dwell_d    = dwell_q;
    snap_d     = snap_q;
    prev_d     = prev_q;
    match_d    = match_q;
    stable_d   = stable_q;
    event_fire = 1'b0;
    col_n      = 4'hF;
    case (state_q)
      ST_SCAN: begin
        col_n = ~(4'b0001 << col_q);
        if (dwell_q == DwellLast) begin
          // Sample late in the dwell so the column has settled and the
          // synchronizer holds rows taken while this column was driven.
          snap_d[{col_q, 2'b00} +: 4] = ~row_sync_q;
          dwell_d = '0;
          if (col_q == 2'd3) begin
            state_d = ST_EVAL;
            col_d   = 2'd0;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      ST_EVAL: begin
        state_d = ST_SCAN;
        if (snap_q == prev_q) begin
          if (match_q != MatchLast) begin
            match_d = match_q + MW'(1);
          end
        end else begin
          prev_d  = snap_q;
          match_d = '0;
        end
        if (match_d == MatchLast) begin
          stable_d = snap_q;
          // Only a lone key that was not already accepted produces an event.
          if (single_key && (|(snap_q & ~stable_q))) begin
            event_fire = 1'b1;
          end
        end
      end
      default: state_d = ST_SCAN;
    endcase
  end

  // One-entry output buffer; a new event may replace a consumed one on the
  // same edge, otherwise it is dropped and flagged.
  always_comb begin
    valid_d = valid_q;
    code_d  = code_q;
    ovf_d   = ovf_q;
    if (event_fire) begin
      if (valid_q && !key_ready) begin
        ovf_d = 1'b1;
      end else begin
        valid_d = 1'b1;
        code_d  = idx;
      end
    end else if (valid_q && key_ready) begin
      valid_d = 1'b0;
    end
  end

  // State register for scanner, debouncer and output buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_SCAN;
      col_q    <= 2'd0;
      dwell_q  <= '0;
      snap_q   <= '0;
      prev_q   <= '0;
      stable_q <= '0;
      match_q  <= '0;
      valid_q  <= 1'b0;
      code_q   <= 4'd0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      dwell_q  <= dwell_d;
      snap_q   <= snap_d;
      prev_q   <= prev_d;
      stable_q <= stable_d;
      match_q  <= match_d;
      valid_q  <= valid_d;
      code_q   <= code_d;
      ovf_q    <= ovf_d;
    end
  end

  assign key_valid = valid_q;
  assign key_code  = code_q;
  assign key_held  = |stable_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_aux_keypad_scanner.sv
// tb/tb_aux_keypad_scanner.sv - randomized scan-level checking of aux_keypad_scanner

module tb_aux_keypad_scanner;

  localparam int ScanCntMax  = 4;
  localparam int DebounceCnt = 2;
  localparam int P           = 4 * ScanCntMax + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic       key_ready = 1'b0;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;
  logic       overflow;

  logic [15:0] keys      = 16'h0;
  logic [15:0] next_keys = 16'h0;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  int          t;
  logic [15:0] hist[$];
  logic [15:0] m_stable;
  logic        m_valid;
  logic [3:0]  m_code;
  logic        m_ovf;
  int          evals_seen;

  aux_keypad_scanner #(
    .ScanCntMax (ScanCntMax),
    .DebounceCnt(DebounceCnt)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .col_n    (col_n),
    .row_n    (row_n),
    .key_ready(key_ready),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_held (key_held),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key shorts its row to a driven-low column.
  always_comb begin
    row_n = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!col_n[c] && keys[c*4+r]) row_n[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0d)", tag, got, exp, t);
    end
  endtask

  task automatic model_reset();
    t = 0;
    hist.delete();
    hist.push_back(16'h0);
    m_stable = 16'h0;
    m_valid  = 1'b0;
    m_code   = 4'h0;
    m_ovf    = 1'b0;
  endtask

  function automatic logic [3:0] exp_col(input int tt);
    int ph;
    logic [3:0] onehot;
    ph = tt % P;
    if (ph == P - 1) return 4'hF;
    onehot = 4'b0001 << (ph / ScanCntMax);
    return ~onehot;
  endfunction

  // Predict the effect of the upcoming clock edge at scan granularity.
  task automatic model_edge(input logic rdy);
    logic        ev;
    logic [3:0]  code;
    logic [15:0] snap;
    logic        all_eq;
    ev   = 1'b0;
    code = 4'h0;
    if (t % P == P - 1) begin
      snap = keys;
      hist.push_back(snap);
      if (hist.size() > DebounceCnt) void'(hist.pop_front());
      all_eq = (hist.size() == DebounceCnt);
      foreach (hist[i]) if (hist[i] != snap) all_eq = 1'b0;
      if (all_eq) begin
        if ($countones(snap) == 1 && (snap & ~m_stable) != 16'h0) begin
          ev = 1'b1;
          for (int i = 0; i < 16; i++) if (snap[i]) code = 4'(i);
        end
        m_stable = snap;
      end
    end
    if (ev) begin
      if (m_valid && !rdy) m_ovf = 1'b1;
      else begin
        m_valid = 1'b1;
        m_code  = code;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    t++;
  endtask

  // One clock cycle: compare outputs, then drive inputs for the next edge.
  task automatic step(input logic rdy, input logic rs);
    logic was_eval;
    @(negedge clk);
    check("col_n", {12'h0, col_n}, {12'h0, exp_col(t)});
    check("key_valid", {15'h0, key_valid}, {15'h0, m_valid});
    check("key_code", {12'h0, key_code}, {12'h0, m_code});
    check("key_held", {15'h0, key_held}, {15'h0, (m_stable != 16'h0)});
    check("overflow", {15'h0, overflow}, {15'h0, m_ovf});
    key_ready = rdy;
    rst       = rs;
    if (rs) begin
      model_reset();
    end else begin
      was_eval = (t % P == P - 1);
      model_edge(rdy);
      if (was_eval) begin
        keys = next_keys;
        evals_seen++;
      end
    end
  endtask

  task automatic run_scans(input logic [15:0] k, input int n, input int ready_pct);
    int target;
    next_keys = k;
    target    = evals_seen + n;
    while (evals_seen < target)
      step(($urandom_range(0, 99) < ready_pct), 1'b0);
  endtask

  initial begin
    int choice, hold, pct, a, b;
    logic [15:0] k;
    evals_seen = 0;
    model_reset();

    repeat (3) step(1'b0, 1'b1);
    run_scans(16'h0000, 2, 0);

    // Single press of key 6 with no consumer, then a one-cycle handshake.
    run_scans(16'h0040, 4, 0);
    step(1'b1, 1'b0);
    run_scans(16'h0040, 3, 0);
    run_scans(16'h0000, 4, 0);

    // Bounce on key 0 followed by a steady hold.
    for (int i = 0; i < 6; i++) run_scans((i % 2 == 0) ? 16'h0001 : 16'h0000, 1, 100);
    run_scans(16'h0001, 4, 100);
    run_scans(16'h0000, 3, 100);

    // Two keys together, then an event dropped into a full buffer.
    run_scans(16'h1008, 4, 100);
    run_scans(16'h0000, 3, 0);
    run_scans(16'h0020, 4, 0);
    run_scans(16'h0000, 3, 0);
    run_scans(16'h0200, 4, 0);
    step(1'b0, 1'b1);
    run_scans(16'h0000, 2, 0);

    // Reset while an event is pending with the key still down.
    run_scans(16'h0080, 4, 0);
    step(1'b0, 1'b1);
    run_scans(16'h0080, 4, 0);
    run_scans(16'h0000, 3, 100);

    // Randomized key patterns, consumer behaviour and occasional resets.
    for (int it = 0; it < 150; it++) begin
      choice = $urandom_range(0, 9);
      a = $urandom_range(0, 15);
      b = $urandom_range(0, 15);
      if (choice < 3)      k = 16'h0;
      else if (choice < 7) k = 16'h1 << a;
      else if (choice < 9) k = (16'h1 << a) | (16'h1 << b);
      else                 k = 16'($urandom);
      hold = $urandom_range(1, 4);
      case ($urandom_range(0, 2))
        0:       pct = 0;
        1:       pct = 30;
        default: pct = 100;
      endcase
      if ($urandom_range(0, 14) == 0) begin
        repeat ($urandom_range(0, P)) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
      end
      run_scans(k, hold, pct);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
